// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock)
// with start/done handshake, overflow detection and optional signed input.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | one add-3/shift step per cycle, BIN_W cycles
// DONE  | one cycle, done=1, new result visible; start re-accepts here
module bcd_convert_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [BIN_W-1:0]    sreg;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] corr;
  logic [4*DIGITS-1:0] work_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                neg_w;
  logic                ovf_w;
  logic                ovf_nxt;
  logic                in_neg;
  logic [BIN_W-1:0]    mag;

  // Negating -2^(BIN_W-1) in BIN_W bits yields the same pattern, which is the
  // correct unsigned magnitude.
  assign in_neg = (SIGNED != 0) && bin_in[BIN_W-1];
  assign mag    = in_neg ? (~bin_in + 1'b1) : bin_in;

  always_comb begin
    corr = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // A corrected top digit with its MSB set would shift out of the register.
  assign work_nxt = {corr[4*DIGITS-2:0], sreg[BIN_W-1]};
  assign ovf_nxt  = ovf_w | corr[4*DIGITS-1];

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      work     <= '0;
      cnt      <= '0;
      neg_w    <= 1'b0;
      ovf_w    <= 1'b0;
      bcd_out  <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          work  <= work_nxt;
          sreg  <= {sreg[BIN_W-2:0], 1'b0};
          ovf_w <= ovf_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            bcd_out  <= work_nxt;
            overflow <= ovf_nxt;
            neg      <= neg_w;
          end
        end
        default: begin
          if (start) begin
            state <= SHIFT;
            sreg  <= mag;
            neg_w <= in_neg;
            work  <= '0;
            ovf_w <= 1'b0;
            cnt   <= CNT_W'(BIN_W);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench for bcd_convert_seq: several parameter sets run in parallel,
// each with its own driver, expected-result queue and output monitor.
module tb_bcd_convert_seq;

  typedef struct packed {
    logic [63:0] bcd;
    logic        ovf;
    logic        neg;
    int          acc;
  } exp_t;

  localparam int NCFG  = 8;
  localparam int CFG_W [NCFG] = '{16, 16, 8, 4, 32, 16, 32, 4};
  localparam int CFG_D [NCFG] = '{ 5,  4, 5, 1, 10, 10,  5, 5};
  localparam int CFG_S [NCFG] = '{ 0,  0, 1, 0,  1,  1,  0, 1};
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int blocks_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int cfg);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
    end
  endtask

  // Decimal reference: magnitude by arithmetic, digits by repeated division.
  function automatic exp_t model(input longint unsigned v, input int w, input int d, input int s, input int acc);
    exp_t e;
    longint unsigned mag;
    longint unsigned lim;
    e     = '0;
    e.acc = acc;
    v     = v & ((64'd1 << w) - 1);
    e.neg = (s != 0) && (((v >> (w - 1)) & 1) == 1);
    mag   = e.neg ? ((64'd1 << w) - v) : v;
    lim   = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    mag   = mag % lim;
    for (int i = 0; i < d; i++) begin
      e.bcd = e.bcd | ((mag % 10) << (4 * i));
      mag   = mag / 10;
    end
    return e;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W = CFG_W[g];
    localparam int D = CFG_D[g];
    localparam int S = CFG_S[g];

    logic           rst_n = 1'b0;
    logic           rst_q = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   bin_in = '0;
    logic           busy, done, neg, overflow;
    logic [4*D-1:0] bcd_out;

    exp_t        q[$];
    exp_t        e;
    logic [63:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;
    logic        hold_neg = 1'b0;
    int          busy_run = 0;

    bcd_convert_seq #(.BIN_W(W), .DIGITS(D), .SIGNED(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .neg      (neg),
      .overflow (overflow)
    );

    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
      if (cyc > 0) begin
        if (!rst_q) begin
          check("rst_busy", 64'(busy), 64'd0, g);
          check("rst_done", 64'(done), 64'd0, g);
          check("rst_bcd", 64'(bcd_out), 64'd0, g);
          check("rst_ovf", 64'(overflow), 64'd0, g);
          check("rst_neg", 64'(neg), 64'd0, g);
          hold_bcd = '0;
          hold_ovf = 1'b0;
          hold_neg = 1'b0;
          busy_run = 0;
        end else if (done) begin
          check("busy_with_done", 64'(busy), 64'd0, g);
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cfg%0d unexpected_done: got done with bcd %0h, expected no outstanding conversion", g, bcd_out);
          end else begin
            e = q.pop_front();
            check("bcd", 64'(bcd_out), e.bcd, g);
            check("overflow", 64'(overflow), 64'(e.ovf), g);
            check("neg", 64'(neg), 64'(e.neg), g);
            check("latency", 64'(cyc + 1 - e.acc), 64'(W + 1), g);
            check("busy_cycles", 64'(busy_run), 64'(W), g);
            hold_bcd = e.bcd;
            hold_ovf = e.ovf;
            hold_neg = e.neg;
          end
          busy_run = 0;
        end else begin
          check("hold_bcd", 64'(bcd_out), hold_bcd, g);
          check("hold_ovf", 64'(overflow), 64'(hold_ovf), g);
          check("hold_neg", 64'(neg), 64'(hold_neg), g);
          if (busy) busy_run++;
        end
      end
    end

    // Called just after a rising edge; start/bin_in are scrambled while the
    // DUT is shifting, and only the value on the accepting edge is expected.
    task automatic send(input logic [W-1:0] v, input bit gap, input bit hold_hi);
      int n;
      n = 0;
      while (busy) begin
        start  = hold_hi ? 1'b1 : 1'($urandom_range(0, 1));
        bin_in = W'($urandom);
        n++;
        if (n > 2 * W + 8) begin
          checks++;
          failures++;
          $display("FAIL cfg%0d accept_timeout: busy still high after %0d cycles, expected low within %0d", g, n, 2 * W + 8);
          return;
        end
        @(posedge clk); #1;
      end
      start  = 1'b1;
      bin_in = v;
      q.push_back(model(64'(v), W, D, S, cyc + 1));
      @(posedge clk); #1;
      if (!hold_hi) start = 1'b0;
      if (gap) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    endtask

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 9))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      case (g)
        0: begin
          send(W'(1234), 1'b0, 1'b0);
          send(W'(16'hFFFF), 1'b1, 1'b0);
          send(W'(0), 1'b1, 1'b0);
          for (int i = 0; i < 5; i++) send(pick(), 1'b0, 1'b1);
          start = 1'b0;
          repeat (W + 3) @(posedge clk);
          #1;
          start  = 1'b1;
          bin_in = W'(1234);
          @(posedge clk); #1;
          start = 1'b0;
          repeat (6) @(posedge clk);
          #1 rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          send(W'(42), 1'b1, 1'b0);
        end
        1: begin
          send(W'(12345), 1'b1, 1'b0);
          send(W'(99), 1'b1, 1'b0);
        end
        2: begin
          send(W'(8'hFF), 1'b1, 1'b0);
          send(W'(8'h80), 1'b1, 1'b0);
          send(W'(8'h7F), 1'b1, 1'b0);
        end
        default: ;
      endcase
      for (int i = 0; i < NRAND; i++)
        send(pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      start = 1'b0;
      repeat (2 * W + 6) @(posedge clk);
      #1 check("drain", 64'(q.size()), 64'd0, g);
      blocks_done++;
    end
  end

  initial begin
    fork
      wait (blocks_done == NCFG);
      begin
        repeat (95000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog: %0d of %0d configurations finished, expected all", blocks_done, NCFG);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_convert_seq.md
# bcd_convert_seq

Sequential, parametrised binary-to-BCD converter for the IO module's display and readout path. It uses the shift-and-add-3 (double-dabble) algorithm, one input bit per clock, so any input width costs one set of per-digit add-3 correctors. It adds a start/done handshake, a configurable digit count, overflow detection and an optional two's-complement signed mode. Results feed the seven-segment / readout logic and are held stable between conversions.

## Interface
- BIN_W, 16: binary input width in bits; must be ≥ 2.
- DIGITS, 5: number of BCD output digits; must be ≥ 1.
- SIGNED, 0: 1 means `bin_in` is two's complement and the magnitude is converted; 0 means unsigned.
- clk  input  1  single system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a conversion; sampled only when `busy`=0.
- bin_in  input  BIN_W  value to convert; captured on the accepting edge.
- busy  output  1  high while a conversion is shifting.
- done  output  1  one-cycle pulse when `bcd_out`, `neg` and `overflow` update.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in [3:0].
- neg  output  1  input was negative (SIGNED=1 only; 0 when SIGNED=0).
- overflow  output  1  the value did not fit in DIGITS digits; `bcd_out` then holds the low DIGITS digits.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (rst_n=0 at an edge): state=IDLE; `busy`=0, `done`=0, `bcd_out`=0, `neg`=0, `overflow`=0; internal registers are cleared.
- IDLE/DONE with start=1:
  - Capture the magnitude into the shift register: `bin_in` if unsigned or non-negative, otherwise its two's-complement negation computed in BIN_W bits.
  - Capture the sign, clear the working BCD register and the overflow flag.
  - Load bit counter = BIN_W, go to SHIFT.
- Magnitude rule: for SIGNED=1 and `bin_in`=-2^(BIN_W-1), the magnitude 2^(BIN_W-1) is representable as unsigned BIN_W bits and must convert correctly.
- SHIFT, each cycle:
  - For every working digit ≥5, add 3 to that digit (all digits evaluated in parallel on the pre-shift value).
  - Then shift {working BCD, shift register} left by 1; the shift register MSB enters BCD bit 0.
  - If the corrected top-digit MSB is 1 before the shift, set the sticky overflow flag.
  - Decrement the counter. When the counter goes 1→0, go to DONE.
- DONE (one cycle):
  - `bcd_out`, `neg` and `overflow` are registered from the working values.
  - `done`=1.
  - Next state is IDLE, or SHIFT if start=1 (back-to-back accept).
- IDLE/DONE with start=0: remain in or go to IDLE; outputs hold.
- start while busy=1: ignored, no queueing; `bin_in` changes during SHIFT have no effect.
- Outputs change only in the DONE cycle; between conversions they hold the last result.
- `neg` is 0 for a zero result, including SIGNED=1 with `bin_in`=0.

## Timing
- Accept edge E0 (start=1, busy=0).
- busy=1 during the cycles following edges E0..E(BIN_W-1); BIN_W shift cycles.
- Edge E(BIN_W) enters DONE: done=1 and new outputs are visible in the cycle after E(BIN_W).
- Latency from the accept edge to done: BIN_W+1 cycles.
- Back-to-back throughput: one result per BIN_W+1 cycles.
- `busy` and `done` are never high in the same cycle.
- Reset during SHIFT or DONE: no done pulse is issued, outputs go to 0 on that edge, and start is accepted on the first edge with rst_n=1.

## Test plan
- Defaults, unsigned:
  - bin_in=16'd1234, start for 1 cycle -> done exactly 17 cycles after the accept edge; bcd_out=20'h01234, overflow=0, busy high for 16 cycles.
  - bin_in=16'hFFFF -> bcd_out=20'h65535, overflow=0.
  - bin_in=0 -> bcd_out=0, neg=0.
- DIGITS=4, bin_in=16'd12345 -> overflow=1, bcd_out=16'h2345; a following conversion of 16'd99 -> overflow=0, bcd_out=16'h0099.
- SIGNED=1, BIN_W=8:
  - bin_in=8'hFF -> neg=1, bcd_out=20'h00001.
  - bin_in=8'h80 -> neg=1, bcd_out=20'h00128.
  - bin_in=8'h7F -> neg=0, bcd_out=20'h00127.
- Handshake:
  - start held high continuously with bin_in changing -> a new accept at every DONE, each result matching the value present on its own accept edge.
  - A start pulse mid-SHIFT is ignored.
- rst_n=0 for one edge at shift cycle 7 -> no done pulse, all outputs 0; the next start converts 16'd42 -> bcd_out=20'h00042.
- Random regression: 1000 random inputs per configuration (BIN_W ∈ {4, 16, 32}, DIGITS ∈ {1, 5, 10}, SIGNED ∈ {0, 1}), compared against a reference model; done latency is always BIN_W+1.
